// File: rtl/synth_pkg.sv
// Shared synth definitions: tone codes for the white keys A3..A5 and voice sizing.
// The tone-to-period lookup imports this package as well.
package synth_pkg;

  localparam int TONE_W     = 4;
  localparam int NUM_VOICES = 4;
  localparam int RANK_W     = 2;

  typedef logic [TONE_W-1:0] tone_t;
  typedef logic [RANK_W-1:0] rank_t;

  localparam tone_t SILENT = 4'd0;
  localparam tone_t A3 = 4'd1;
  localparam tone_t B3 = 4'd2;
  localparam tone_t C4 = 4'd3;
  localparam tone_t D4 = 4'd4;
  localparam tone_t E4 = 4'd5;
  localparam tone_t F4 = 4'd6;
  localparam tone_t G4 = 4'd7;
  localparam tone_t A4 = 4'd8;
  localparam tone_t B4 = 4'd9;
  localparam tone_t C5 = 4'd10;
  localparam tone_t D5 = 4'd11;
  localparam tone_t E5 = 4'd12;
  localparam tone_t F5 = 4'd13;
  localparam tone_t G5 = 4'd14;
  localparam tone_t A5 = 4'd15;

  // Key bit i plays tone code i+1; code 0 is reserved for silence.
  function automatic tone_t key_tone(input logic [TONE_W-1:0] idx);
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/lsb_pick.sv
// Lowest-set-bit priority encoder: index of the lowest request and a valid flag.
module lsb_pick #(
  parameter int N  = 15,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: queues key press/release edges, serves one per cycle
// (releases first) and steals the oldest-allocated voice when all four are busy.
module voice_alloc
  import synth_pkg::*;
#(
  parameter int NUM_KEYS = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_KEYS-1:0]   keys,
  output logic [TONE_W-1:0]     tone0,
  output logic [TONE_W-1:0]     tone1,
  output logic [TONE_W-1:0]     tone2,
  output logic [TONE_W-1:0]     tone3,
  output logic [NUM_VOICES-1:0] voice_busy,
  output logic                  steal
);

  localparam int KW = $clog2(NUM_KEYS);
  localparam int VW = $clog2(NUM_VOICES);

  logic [NUM_KEYS-1:0] keys_q, press_pend_reg, rel_pend_reg;
  logic [NUM_KEYS-1:0] press_pend_next, rel_pend_next;
  logic [NUM_KEYS-1:0] press_edge, rel_edge, p_set, r_set;
  tone_t               tone_reg  [NUM_VOICES];
  tone_t               tone_next [NUM_VOICES];
  rank_t               rank_reg  [NUM_VOICES];
  rank_t               rank_next [NUM_VOICES];
  logic                steal_reg, steal_next;

  logic [KW-1:0]         p_idx, r_idx;
  logic                  p_vld, r_vld, f_vld;
  logic [VW-1:0]         f_idx, oldest_idx, target;
  logic [NUM_VOICES-1:0] free_mask, hit, rel_match;

  assign press_edge = keys & ~keys_q;
  assign rel_edge   = ~keys & keys_q;
  // A fresh edge cancels any still-queued opposite event on the same key.
  assign p_set = (press_pend_reg | press_edge) & ~rel_edge;
  assign r_set = (rel_pend_reg | rel_edge) & ~press_edge;

  lsb_pick #(.N(NUM_KEYS)) u_pick_press (.req(p_set), .idx(p_idx), .valid(p_vld));
  lsb_pick #(.N(NUM_KEYS)) u_pick_rel   (.req(r_set), .idx(r_idx), .valid(r_vld));
  lsb_pick #(.N(NUM_VOICES)) u_pick_free (.req(free_mask), .idx(f_idx), .valid(f_vld));

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    assign free_mask[gi] = (tone_reg[gi] == SILENT);
    assign hit[gi]       = (tone_reg[gi] == key_tone(p_idx));
    assign rel_match[gi] = (tone_reg[gi] == key_tone(r_idx));
  end

  always_comb begin
    oldest_idx = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rank_reg[v] == rank_t'(NUM_VOICES - 1)) oldest_idx = VW'(v);
    end
  end

  always_comb begin
    tone_next       = tone_reg;
    rank_next       = rank_reg;
    steal_next      = 1'b0;
    press_pend_next = p_set;
    rel_pend_next   = r_set;
    target          = f_vld ? f_idx : oldest_idx;
    if (r_vld) begin
      rel_pend_next[r_idx] = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (rel_match[v]) tone_next[v] = SILENT;
      end
    end else if (p_vld) begin
      press_pend_next[p_idx] = 1'b0;
      if (!(|hit)) begin
        steal_next        = !f_vld;
        tone_next[target] = key_tone(p_idx);
        // Move the target to the youngest slot; everyone younger ages by one.
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (rank_reg[v] < rank_reg[target]) rank_next[v] = rank_reg[v] + 1'b1;
        end
        rank_next[target] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_q         <= '0;
      press_pend_reg <= '0;
      rel_pend_reg   <= '0;
      steal_reg      <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        tone_reg[v] <= SILENT;
        rank_reg[v] <= rank_t'(v);
      end
    end else begin
      keys_q         <= keys;
      press_pend_reg <= press_pend_next;
      rel_pend_reg   <= rel_pend_next;
      steal_reg      <= steal_next;
      tone_reg       <= tone_next;
      rank_reg       <= rank_next;
    end
  end

  assign tone0      = tone_reg[0];
  assign tone1      = tone_reg[1];
  assign tone2      = tone_reg[2];
  assign tone3      = tone_reg[3];
  assign voice_busy = ~free_mask;
  assign steal      = steal_reg;

endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc: hand-computed vector table, directed reset/backlog
// sequences, then random key traffic against an age-queue reference model.
module tb_voice_alloc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] keys;
  logic [3:0]  tone0, tone1, tone2, tone3;
  logic [3:0]  voice_busy;
  logic        steal;

  int checks = 0;
  int failures = 0;

  voice_alloc dut (
    .clk(clk), .rst_n(rst_n), .keys(keys),
    .tone0(tone0), .tone1(tone1), .tone2(tone2), .tone3(tone3),
    .voice_busy(voice_busy), .steal(steal)
  );

  always #5 clk = ~clk;

  // Reference model: pending sets as key bitmaps, voice age as an ordered queue
  // (front = least recently allocated).
  logic [14:0] m_kq, m_pp, m_rp;
  int          m_tone [4];
  int          m_age [$];
  bit          m_steal;

  task automatic model_reset();
    m_kq = '0; m_pp = '0; m_rp = '0; m_steal = 0;
    for (int v = 0; v < 4; v++) m_tone[v] = 0;
    m_age = {3, 2, 1, 0};
  endtask

  task automatic model_step(input logic [14:0] k);
    logic [14:0] pe, re, p, r;
    int key, tgt;
    bit held;
    pe = k & ~m_kq;
    re = ~k & m_kq;
    m_kq = k;
    p = (m_pp | pe) & ~re;
    r = (m_rp | re) & ~pe;
    m_steal = 0;
    key = -1;
    if (r != 0) begin
      for (int i = 14; i >= 0; i--) if (r[i]) key = i;
      r[key] = 1'b0;
      for (int v = 0; v < 4; v++) if (m_tone[v] == key + 1) m_tone[v] = 0;
    end else if (p != 0) begin
      for (int i = 14; i >= 0; i--) if (p[i]) key = i;
      p[key] = 1'b0;
      held = 0;
      for (int v = 0; v < 4; v++) if (m_tone[v] == key + 1) held = 1;
      if (!held) begin
        tgt = -1;
        for (int v = 3; v >= 0; v--) if (m_tone[v] == 0) tgt = v;
        if (tgt < 0) begin
          tgt = m_age[0];
          m_steal = 1;
        end
        m_tone[tgt] = key + 1;
        for (int j = 0; j < m_age.size(); j++) begin
          if (m_age[j] == tgt) begin
            m_age.delete(j);
            break;
          end
        end
        m_age.push_back(tgt);
      end
    end
    m_pp = p;
    m_rp = r;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    int busy;
    busy = 0;
    for (int v = 0; v < 4; v++) if (m_tone[v] != 0) busy |= (1 << v);
    chk({tag, ".tone0"}, int'(tone0), m_tone[0]);
    chk({tag, ".tone1"}, int'(tone1), m_tone[1]);
    chk({tag, ".tone2"}, int'(tone2), m_tone[2]);
    chk({tag, ".tone3"}, int'(tone3), m_tone[3]);
    chk({tag, ".busy"}, int'(voice_busy), busy);
    chk({tag, ".steal"}, int'(steal), int'(m_steal));
  endtask

  // Starts and ends on a negedge; outputs are sampled at the negedge.
  task automatic cycle(input logic [14:0] k);
    keys = k;
    @(posedge clk);
    model_step(k);
    @(negedge clk);
    $display("keys=%04h tones=%0d,%0d,%0d,%0d busy=%b steal=%b",
             k, tone0, tone1, tone2, tone3, voice_busy, steal);
  endtask

  typedef struct {
    logic [14:0] k;
    logic [15:0] tones;  // {tone3, tone2, tone1, tone0}
    logic [3:0]  busy;
    logic        st;
  } vec_t;

  vec_t tbl [23];

  initial begin
    tbl[0]  = '{15'h0001, 16'h0001, 4'b0001, 1'b0};
    tbl[1]  = '{15'h0000, 16'h0000, 4'b0000, 1'b0};
    tbl[2]  = '{15'h0001, 16'h0001, 4'b0001, 1'b0};
    tbl[3]  = '{15'h0005, 16'h0031, 4'b0011, 1'b0};
    tbl[4]  = '{15'h0015, 16'h0531, 4'b0111, 1'b0};
    tbl[5]  = '{15'h0055, 16'h7531, 4'b1111, 1'b0};
    tbl[6]  = '{15'h0155, 16'h7539, 4'b1111, 1'b1};
    tbl[7]  = '{15'h0155, 16'h7539, 4'b1111, 1'b0};
    tbl[8]  = '{15'h0551, 16'h7509, 4'b1101, 1'b0};
    tbl[9]  = '{15'h0551, 16'h75B9, 4'b1111, 1'b0};
    tbl[10] = '{15'h0000, 16'h75B9, 4'b1111, 1'b0};
    tbl[11] = '{15'h0000, 16'h70B9, 4'b1011, 1'b0};
    tbl[12] = '{15'h0000, 16'h00B9, 4'b0011, 1'b0};
    tbl[13] = '{15'h0000, 16'h00B0, 4'b0010, 1'b0};
    tbl[14] = '{15'h0000, 16'h0000, 4'b0000, 1'b0};
    tbl[15] = '{15'h0007, 16'h0001, 4'b0001, 1'b0};
    tbl[16] = '{15'h0007, 16'h0021, 4'b0011, 1'b0};
    tbl[17] = '{15'h0007, 16'h0321, 4'b0111, 1'b0};
    tbl[18] = '{15'h0008, 16'h0320, 4'b0110, 1'b0};
    tbl[19] = '{15'h0000, 16'h0300, 4'b0100, 1'b0};
    tbl[20] = '{15'h0000, 16'h0000, 4'b0000, 1'b0};
    tbl[21] = '{15'h0000, 16'h0000, 4'b0000, 1'b0};
    tbl[22] = '{15'h0000, 16'h0000, 4'b0000, 1'b0};

    rst_n = 1'b0;
    keys  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.tone0", int'(tone0), 0);
    chk("reset.tone1", int'(tone1), 0);
    chk("reset.tone2", int'(tone2), 0);
    chk("reset.tone3", int'(tone3), 0);
    chk("reset.busy", int'(voice_busy), 0);
    chk("reset.steal", int'(steal), 0);
    rst_n = 1'b1;

    // Directed table: single press, stealing, release-before-press, burst,
    // and a one-cycle press cancelled behind a release backlog.
    for (int i = 0; i < 23; i++) begin
      cycle(tbl[i].k);
      chk($sformatf("vec%0d.tones", i), int'({tone3, tone2, tone1, tone0}), int'(tbl[i].tones));
      chk($sformatf("vec%0d.busy", i), int'(voice_busy), int'(tbl[i].busy));
      chk($sformatf("vec%0d.steal", i), int'(steal), int'(tbl[i].st));
    end

    // Reset in the middle of a press backlog.
    cycle(15'h000F);
    cycle(15'h000F);
    chk("mid.pre_tone1", int'(tone1), 2);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid.async_tone0", int'(tone0), 0);
    chk("mid.async_tone1", int'(tone1), 0);
    chk("mid.async_busy", int'(voice_busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(15'h000F);
      chk_model($sformatf("mid.realloc%0d", i));
    end
    chk("mid.final", int'({tone3, tone2, tone1, tone0}), 16'h4321);

    // All keys held straight out of reset.
    rst_n = 1'b0;
    keys  = 15'h7FFF;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cycle(15'h7FFF);
      chk($sformatf("allhi.steal%0d", i), int'(steal), (i >= 4) ? 1 : 0);
      chk_model($sformatf("allhi%0d", i));
    end
    cycle(15'h7FFF);
    chk("allhi.idle_steal", int'(steal), 0);
    chk("allhi.final", int'({tone3, tone2, tone1, tone0}), 16'hCFED);

    // Random key traffic against the model.
    begin
      logic [14:0] k;
      k = 15'h7FFF;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 2) == 0) k ^= 15'(1 << $urandom_range(0, 14));
        if ($urandom_range(0, 59) == 0) k = 15'($urandom);
        if ($urandom_range(0, 79) == 0) k = '0;
        cycle(k);
        chk_model($sformatf("rand%0d", i));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
